// File: rtl/mul_issue_stage.sv
// Two-stage issue/result wrapper around the combinational multiplier core.
// S1 holds operands driving the core; S2 holds the selected product word for writeback.
module mul_issue_stage #(
    parameter int unsigned TAG_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [1:0]        req_op_i,
    input  logic [31:0]       req_rj_i,
    input  logic [31:0]       req_rk_i,
    input  logic [TAG_W-1:0]  req_tag_i,
    output logic              resp_valid_o,
    input  logic              resp_ready_i,
    output logic [31:0]       resp_data_o,
    output logic [TAG_W-1:0]  resp_tag_o,
    output logic              busy_o,
    output logic              mul_signed_o,
    output logic [31:0]       mul_x_o,
    output logic [31:0]       mul_y_o,
    input  logic [63:0]       mul_res_i
);

    localparam logic [1:0] OP_MULH_W  = 2'b01;
    localparam logic [1:0] OP_MULH_WU = 2'b10;

    logic              s1_valid;
    logic [1:0]        s1_op;
    logic [31:0]       s1_x;
    logic [31:0]       s1_y;
    logic [TAG_W-1:0]  s1_tag;

    logic              s2_valid;
    logic [31:0]       s2_data;
    logic [TAG_W-1:0]  s2_tag;

    logic              s2_free;
    logic              s1_adv;
    logic              accept;
    logic [31:0]       sel_word;

    // Handshake: ready never looks at req_valid_i, so no loop through issue.
    always_comb begin
        s2_free     = !s2_valid || resp_ready_i;
        s1_adv      = s1_valid && s2_free;
        req_ready_o = !flush_i && (!s1_valid || s2_free);
        accept      = req_valid_i && req_ready_o;
        sel_word    = ((s1_op == OP_MULH_W) || (s1_op == OP_MULH_WU))
                      ? mul_res_i[63:32] : mul_res_i[31:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_op    <= 2'b00;
            s1_x     <= 32'd0;
            s1_y     <= 32'd0;
            s1_tag   <= TAG_W'(0);
            s2_valid <= 1'b0;
            s2_data  <= 32'd0;
            s2_tag   <= TAG_W'(0);
        end else if (flush_i) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            // S1 reloads on accept even while it advances into S2.
            if (accept) begin
                s1_valid <= 1'b1;
                s1_op    <= req_op_i;
                s1_x     <= req_rj_i;
                s1_y     <= req_rk_i;
                s1_tag   <= req_tag_i;
            end else if (s1_adv) begin
                s1_valid <= 1'b0;
            end

            if (s1_adv) begin
                s2_valid <= 1'b1;
                s2_data  <= sel_word;
                s2_tag   <= s1_tag;
            end else if (resp_ready_i) begin
                s2_valid <= 1'b0;
            end
        end
    end

    assign mul_x_o      = s1_x;
    assign mul_y_o      = s1_y;
    assign mul_signed_o = s1_valid && (s1_op != OP_MULH_WU);
    assign resp_valid_o = s2_valid;
    assign resp_data_o  = s2_data;
    assign resp_tag_o   = s2_tag;
    assign busy_o       = s1_valid || s2_valid;

endmodule
